// File: rtl/mouse_pkg.sv
// Shared constants, state encoding and bitmap indexing for the handwriting
// capture block; the display side uses the same idx() mapping.
package mouse_pkg;

  localparam int BSIZE   = 52;
  localparam int RW      = 6;
  localparam int TRACK_W = BSIZE * BSIZE;
  localparam int IW      = $clog2(TRACK_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic logic [IW-1:0] idx(input logic [RW-1:0] row, input logic [RW-1:0] col);
    return IW'(row) * IW'(BSIZE) + IW'(col);
  endfunction

endpackage

// File: rtl/track_row_streamer.sv
// Presents rows 0..BSIZE-1 one at a time over a valid/ready handshake and
// pulses done for one cycle after the final row is accepted.
module track_row_streamer #(
  parameter int BSIZE = 52,
  parameter int RW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          row_ready,
  output logic [RW-1:0] row_idx,
  output logic          row_valid,
  output logic          row_last,
  output logic          done,
  output logic          last_hs
);

  localparam logic [RW-1:0] LAST_ROW = RW'(BSIZE - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);

  logic [RW-1:0] r_idx;
  logic          r_valid;
  logic          r_done;
  logic          w_hs;
  logic          w_at_last;

  assign w_hs      = r_valid & row_ready;
  assign w_at_last = (r_idx == LAST_ROW);

  // Row pointer, valid flag and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= ROW_ZERO;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_idx   <= ROW_ZERO;
      r_valid <= 1'b1;
      r_done  <= 1'b0;
    end else if (w_hs) begin
      if (w_at_last) begin
        r_idx   <= ROW_ZERO;
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        r_idx   <= r_idx + ROW_ONE;
        r_valid <= 1'b1;
        r_done  <= 1'b0;
      end
    end else begin
      r_done  <= 1'b0;
    end
  end

  assign row_idx   = r_idx;
  assign row_valid = r_valid;
  assign row_last  = r_valid & w_at_last;
  assign done      = r_done;
  assign last_hs   = w_hs & w_at_last;

endmodule

// File: rtl/mouse_track_recorder.sv
// Records pen strokes inside the handwriting block into a BSIZE x BSIZE bitmap
// and, on submit, streams the frozen bitmap row by row to the recogniser.
module mouse_track_recorder
  import mouse_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               block_x_pos,
  input  logic [9:0]               block_y_pos,
  input  logic [9:0]               mouse_x,
  input  logic [9:0]               mouse_y,
  input  logic                     mouse_left,
  input  logic                     clear_req,
  input  logic                     submit_req,
  output logic [TRACK_W-1:0]       track,
  output logic                     busy,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [BSIZE-1:0]         row_data,
  output logic [RW-1:0]            row_idx,
  output logic                     row_last,
  output logic                     done
);

  state_e             r_state;
  state_e             w_next;
  logic [TRACK_W-1:0] r_track;
  logic               w_start;
  logic               w_last_hs;
  logic               w_inblk;
  logic               w_clr;
  logic               w_wr;
  logic [RW-1:0]      w_col;
  logic [RW-1:0]      w_row;
  logic [IW-1:0]      w_wr_idx;
  logic [IW-1:0]      w_rd_base;
  logic [10:0]        w_x_lo;
  logic [10:0]        w_x_hi;
  logic [10:0]        w_y_lo;
  logic [10:0]        w_y_hi;
  logic [10:0]        w_mx;
  logic [10:0]        w_my;

  // 11-bit compare keeps block_pos+BSIZE from wrapping near the screen edge
  assign w_mx    = {1'b0, mouse_x};
  assign w_my    = {1'b0, mouse_y};
  assign w_x_lo  = {1'b0, block_x_pos};
  assign w_y_lo  = {1'b0, block_y_pos};
  assign w_x_hi  = w_x_lo + 11'(BSIZE);
  assign w_y_hi  = w_y_lo + 11'(BSIZE);
  assign w_inblk = (w_mx >= w_x_lo) && (w_mx < w_x_hi) &&
                   (w_my >= w_y_lo) && (w_my < w_y_hi);

  // Only the low RW bits of the offset matter once the cursor is in the block
  assign w_col    = mouse_x[RW-1:0] - block_x_pos[RW-1:0];
  assign w_row    = mouse_y[RW-1:0] - block_y_pos[RW-1:0];
  assign w_wr_idx = idx(w_row, w_col);

  assign w_clr = clear_req && (r_state != SEND);
  assign w_wr  = (r_state == DRAW) && w_inblk;

  // Next-state selection; clear suppresses a coincident submit
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE, DRAW: begin
        if (submit_req && !clear_req) begin
          w_next  = SEND;
          w_start = 1'b1;
        end else if (mouse_left) begin
          w_next  = DRAW;
        end else begin
          w_next  = IDLE;
        end
      end
      SEND: begin
        if (w_last_hs) begin
          w_next = IDLE;
        end else begin
          w_next = SEND;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bitmap storage: clear wins over a draw write, drawing only ever sets bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_track <= {TRACK_W{1'b0}};
    end else if (w_clr) begin
      r_track <= {TRACK_W{1'b0}};
    end else if (w_wr) begin
      r_track[w_wr_idx] <= 1'b1;
    end else begin
      r_track <= r_track;
    end
  end

  track_row_streamer #(
    .BSIZE (BSIZE),
    .RW    (RW)
  ) u_streamer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .row_last  (row_last),
    .done      (done),
    .last_hs   (w_last_hs)
  );

  assign w_rd_base = idx(row_idx, {RW{1'b0}});
  assign row_data  = r_track[w_rd_base +: BSIZE];
  assign track     = r_track;
  assign busy      = (r_state == SEND);

endmodule

// File: doc/mouse_track_recorder.md
Name: mouse_track_recorder

Overview:
- Captures the user's handwritten stroke into a BSIZE x BSIZE bit-plane ("track").
- Writes one bit per clock while the left button is held and the cursor is inside the handwriting block.
- Drives the track vector consumed by the track display path.
- On submit, streams the frozen bitmap row by row to the digit recogniser over a valid/ready handshake.

Parameters:
- BSIZE, 52, side of the square handwriting block in pixels; track width is BSIZE*BSIZE.
- RW, 6, row-index width; must satisfy 2**RW >= BSIZE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- block_x_pos  input  10  left edge of the handwriting block, in mirrored display coordinates
- block_y_pos  input  10  top edge of the handwriting block, in mirrored display coordinates
- mouse_x  input  10  cursor x, same coordinate frame as block_x_pos, synchronous to clk
- mouse_y  input  10  cursor y, same coordinate frame as block_y_pos, synchronous to clk
- mouse_left  input  1  left-button level (pen down)
- clear_req  input  1  single-cycle pulse: erase the track
- submit_req  input  1  single-cycle pulse: stream the track to the recogniser
- track  output  BSIZE*BSIZE  captured bitmap; bit index = row*BSIZE+col
- busy  output  1  high while in SEND
- row_valid  output  1  row_data is valid
- row_ready  input  1  recogniser accepts the current row
- row_data  output  BSIZE  equals track[row_idx*BSIZE +: BSIZE]
- row_idx  output  RW  index of the row being presented
- row_last  output  1  high while row_valid is high and row_idx == BSIZE-1
- done  output  1  single-cycle pulse after the last row handshake

Behaviour:
- Reset (asynchronous, rst_n low):
  - track = 0, state = IDLE, row_idx = 0.
  - row_valid, busy, done = 0.
  - Any in-progress SEND is abandoned with no handshake completed.
- In-block test:
  - inblk = mouse_x >= block_x_pos && mouse_x < block_x_pos+BSIZE && mouse_y >= block_y_pos && mouse_y < block_y_pos+BSIZE.
  - Compare in 11 bits so that block_pos+BSIZE does not wrap.
  - col = mouse_x-block_x_pos and row = mouse_y-block_y_pos, each RW bits.
- States:
  - IDLE (pen up), DRAW (pen down), SEND (streaming).
  - IDLE->DRAW when mouse_left=1.
  - DRAW->IDLE when mouse_left=0.
  - IDLE or DRAW -> SEND on submit_req (unless clear_req is also high).
  - SEND->IDLE on the handshake with row_last=1.
- Drawing:
  - In DRAW, each cycle with inblk=1 sets track[row*BSIZE+col]; visible on track the next cycle.
  - Bits are only ever set, never cleared, by drawing.
  - Out-of-block samples are ignored; the state remains DRAW.
- Clear:
  - clear_req in IDLE or DRAW zeroes the entire track in one cycle; the state is unchanged.
  - clear_req has priority over a draw write in the same cycle.
  - clear_req has priority over a simultaneous submit_req; the submit is dropped.
  - clear_req in SEND is ignored.
- Submit:
  - On entering SEND: row_idx = 0, row_valid = 1, busy = 1. The first row is presented the cycle after submit_req.
  - Track is frozen during SEND: mouse_left, clear_req and submit_req are all ignored.
  - Handshake = row_valid && row_ready. On each handshake, row_idx increments.
  - row_valid stays high and row_data stays stable until the handshake. Deasserting row_ready stalls indefinitely.
  - Handshake on row BSIZE-1:
    - row_valid = 0, busy = 0, row_idx = 0, done = 1 for one cycle.
    - State returns to IDLE even if mouse_left is still held; drawing resumes through the normal IDLE->DRAW transition on the next cycle.
  - The track is retained after SEND; erasing it requires an explicit clear_req.
- Throughput: one row per cycle with row_ready tied high, so a full send takes BSIZE cycles.
- row_data is combinational from the registered track and row_idx.

Decomposition:
- Shared package mouse_pkg holds:
  - BSIZE, the state encodings IDLE/DRAW/SEND, RW.
  - The track index function idx(row,col) = row*BSIZE+col, shared with the display side.
- One natural sub-module, track_row_streamer:
  - Owns row_idx, row_valid, row_last and done.
  - Driven by start and row_ready.
- Bitmap storage and the state machine stay in the top level.

Test Plan:
- Reset check: assert rst_n=0 mid-SEND at row_idx=17 -> track==0, row_valid=0, busy=0, row_idx=0 on the same edge.
- Single draw: block=(100,200), mouse=(110,205), mouse_left=1 for 1 cycle -> only track[5*52+10]=1 the next cycle. Cursor moved to (152,205) -> no new bit, because x=152 is outside the block.
- Clear priority: clear_req with mouse_left=1 inside the block -> track==0 that cycle. Drawing at (101,201) the next cycle sets bit 53 only.
- Clear beats submit: simultaneous clear_req and submit_req -> track==0, state stays IDLE, row_valid stays 0.
- Stream with ready tied high:
  - Setup: bits 0 and 2703 set.
  - Expect row_valid for exactly 52 cycles, row_data[0]=1 at row_idx 0, row_data[51]=1 at row_idx 51 with row_last=1.
  - Expect done pulse one cycle later; track is unchanged.
- Backpressure during SEND:
  - Setup: row_ready toggled 0,0,1 repeatedly.
  - Expect row_data/row_idx stable while stalled, 156 cycles total.
  - Expect clear_req and submit_req during SEND to have no effect, and mouse_left=1 inside the block to set no bits.
